// File: rtl/zcntr.sv
// -----------------------------------------------------------------------------
// zcntr -- zero-run event counter
//
// Purpose:
//   Watches an adjustment value on every rising clock edge. It counts the
//   number of separate runs of zero it has seen. A run is one or more
//   back-to-back samples equal to zero. A run is counted on its first sample.
//   The counter re-arms only after a nonzero sample.
//
// Parameters:
//   DATA_W   - width of adj_val
//   CNT_W    - width of the run counter / zCnt
//   SATURATE - 1: counter sticks at 2^CNT_W-1; 0: counter wraps to 0
//
// Ports:
//   clk      in   1       system clock, all state updates on the rising edge
//   rst      in   1       synchronous active-high reset
//   adj_val  in   DATA_W  adjustment value, sampled every rising edge
//   zCnt     out  CNT_W   registered count of zero runs
// -----------------------------------------------------------------------------
module zcntr #(
    parameter int DATA_W   = 7,
    parameter int CNT_W    = 4,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] adj_val,
    output logic [CNT_W-1:0]  zCnt
);

    logic             r_prev_zero;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cnt_next;

    logic             w_is_zero;
    logic             w_run_start;
    logic             w_inc_en;

    // Full-width compare: any set bit, including the MSB, counts as nonzero.
    assign w_is_zero   = (adj_val == '0);

    // A run begins on a zero sample whose previous sample was not zero.
    // r_prev_zero clears on reset. A zero held through reset deassertion
    // therefore counts as a new run at the first edge after reset.
    assign w_run_start = w_is_zero & ~r_prev_zero;

    generate
        if (SATURATE) begin : g_sat
            logic w_at_max;
            assign w_at_max = (r_cnt == {CNT_W{1'b1}});
            // Block the increment at full scale so the count holds there.
            assign w_inc_en = w_run_start & ~w_at_max;
        end else begin : g_wrap
            // The natural modulo-2^CNT_W rollover of the adder does the wrap.
            assign w_inc_en = w_run_start;
        end
    endgenerate

    always_comb begin
        r_cnt_next = r_cnt;
        if (w_inc_en) begin
            r_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_prev_zero <= 1'b0;
        end else begin
            r_cnt       <= r_cnt_next;
            r_prev_zero <= w_is_zero;
        end
    end

    // zCnt is driven straight from the register, so adj_val has no
    // combinational path to the output.
    assign zCnt = r_cnt;

endmodule

// File: tb/tb_zcntr.sv
// -----------------------------------------------------------------------------
// tb_zcntr -- self-checking bench for zcntr
//
// The bench runs two instances side by side, one saturating and one wrapping.
// Both instances get the same stimulus. The reference model keeps the list of
// samples taken since the last reset. From that list it counts the zero runs
// directly: a run starts at each zero that is first in the list or that
// follows a nonzero sample. It then applies clamping or modulo to get the
// expected count.
// -----------------------------------------------------------------------------
module tb_zcntr;

    localparam int DATA_W = 7;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] adj_val;
    logic [CNT_W-1:0]  zcnt_sat;
    logic [CNT_W-1:0]  zcnt_wrap;

    int tests_run    = 0;
    int tests_failed = 0;

    // Samples taken since the last reset edge.
    logic [DATA_W-1:0] hist[$];

    zcntr #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SATURATE(1'b1)) u_dut_sat (
        .clk     (clk),
        .rst     (rst),
        .adj_val (adj_val),
        .zCnt    (zcnt_sat)
    );

    zcntr #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SATURATE(1'b0)) u_dut_wrap (
        .clk     (clk),
        .rst     (rst),
        .adj_val (adj_val),
        .zCnt    (zcnt_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int observed, input int expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int count_runs();
        int runs = 0;
        for (int i = 0; i < hist.size(); i++) begin
            if (hist[i] == '0 && (i == 0 || hist[i-1] != '0)) runs++;
        end
        return runs;
    endfunction

    // Drive one transaction on the falling edge. Let the rising edge sample it,
    // then update the model and check both instances 1 time unit later.
    task automatic step(input logic r, input logic [DATA_W-1:0] v, input string tag);
        int runs;
        int exp_sat;
        int exp_wrap;
        @(negedge clk);
        rst     = r;
        adj_val = v;
        @(posedge clk);
        #1;
        if (r) hist.delete();
        else   hist.push_back(v);
        runs     = count_runs();
        exp_sat  = (runs > CNT_MAX) ? CNT_MAX : runs;
        exp_wrap = runs % (CNT_MAX + 1);
        $display("[TB] %s rst=%0b adj=%0d zCnt_sat=%0d(exp %0d) zCnt_wrap=%0d(exp %0d)",
                 tag, r, v, zcnt_sat, exp_sat, zcnt_wrap, exp_wrap);
        check_val({tag, "_sat"},  int'(zcnt_sat),  exp_sat);
        check_val({tag, "_wrap"}, int'(zcnt_wrap), exp_wrap);
    endtask

    initial begin
        logic [DATA_W-1:0] v;
        logic              r;
        int                sel;

        rst     = 1'b1;
        adj_val = 7'd50;

        // Reset check: two reset edges, then idle at a nonzero value.
        step(1'b1, 7'd50, "reset0");
        check_val("reset0_const", int'(zcnt_sat), 0);
        step(1'b1, 7'd50, "reset1");
        step(1'b0, 7'd50, "idle0");
        step(1'b0, 7'd50, "idle1");
        check_val("idle_const", int'(zcnt_sat), 0);

        // Isolated zeros: 0,5,0,6,0 gives 1,1,2,2,3.
        step(1'b0, 7'd0, "iso0");
        step(1'b0, 7'd5, "iso1");
        step(1'b0, 7'd0, "iso2");
        step(1'b0, 7'd6, "iso3");
        step(1'b0, 7'd0, "iso4");
        check_val("iso_const", int'(zcnt_sat), 3);

        // Run handling: 10,10,0,0 gives 3,3,4,4.
        step(1'b0, 7'd10, "run0");
        step(1'b0, 7'd10, "run1");
        step(1'b0, 7'd0,  "run2");
        step(1'b0, 7'd0,  "run3");
        check_val("run_const", int'(zcnt_sat), 4);

        // Mid-run reset while the zero is held, then deassert with zero still present.
        step(1'b1, 7'd0, "midrst");
        check_val("midrst_const", int'(zcnt_sat), 0);
        step(1'b0, 7'd0, "post0");
        check_val("post0_const", int'(zcnt_sat), 1);
        step(1'b0, 7'd0, "post1");
        step(1'b0, 7'd0, "post2");

        // Full-width compare: MSB-only and LSB-only values never trigger.
        step(1'b0, 7'd64, "fw0");
        step(1'b0, 7'd1,  "fw1");
        step(1'b0, 7'd64, "fw2");
        check_val("fw_const", int'(zcnt_sat), 1);

        // Saturation / wrap: 20 more zero runs after a fresh reset.
        step(1'b1, 7'd1, "satrst");
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 7'd0, "sat_z");
            step(1'b0, 7'd1, "sat_nz");
        end
        check_val("sat_const", int'(zcnt_sat), CNT_MAX);
        check_val("wrap_const", int'(zcnt_wrap), 20 % (CNT_MAX + 1));

        // Randomised traffic: zero-heavy, with single-bit values and rare resets.
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 40)      v = '0;
            else if (sel < 50) v = 7'd64;
            else if (sel < 55) v = 7'd1;
            else               v = DATA_W'($urandom_range(1, (1 << DATA_W) - 1));
            r = ($urandom_range(0, 59) == 0);
            step(r, v, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
